// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the regfile write-port arbiter.
// Register indices and the grant-source encoding.
package wb_defs;

  localparam logic [4:0] STATUS_REG = 5'd30;
  localparam logic [4:0] REG_ZERO   = 5'd0;

  typedef enum logic [2:0] {
    G_NONE,
    G_ST,
    G_MDEXC,
    G_MD,
    G_PIPE,
    G_PIPE_ST
  } grant_e;

endpackage

// File: rtl/wb_pending_slot.sv
// Single-entry holding slot for a deferred regfile write.
// Set takes precedence over clear; synchronous active-high reset.
module wb_pending_slot (
  input  logic        clock,
  input  logic        reset,
  input  logic        set,
  input  logic        clr,
  input  logic [4:0]  set_rd,
  input  logic [31:0] set_data,
  output logic        v,
  output logic [4:0]  rd,
  output logic [31:0] data
);

  logic        v_q, v_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    v_d    = v_q;
    rd_d   = rd_q;
    data_d = data_q;
    if (clr) v_d = 1'b0;
    if (set) begin
      v_d    = 1'b1;
      rd_d   = set_rd;
      data_d = set_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v_q    <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  assign v    = v_q;
  assign rd   = rd_q;
  assign data = data_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single regfile write port among W-stage primary,
// W-stage rstatus and mult/div completion, with bounded md starvation.
module wb_port_arbiter
  import wb_defs::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        pipe_st_we,
  input  logic [31:0] pipe_st_data,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  input  logic        md_exception,
  output logic        md_ready,
  output logic        stall_pipe,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             st_v, md_v;
  logic [4:0]       st_rd, md_prd;
  logic [31:0]      st_data, md_pdata;
  logic             st_set, st_clr, md_set, md_clr;
  logic             md_exc_q, md_exc_d;
  logic             md_exc_v_q, md_exc_v_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             md_force, stall_int;
  logic             pipe_pw, pipe_any;
  grant_e           grant;

  wb_pending_slot u_st_slot (
    .clock    (clock),
    .reset    (reset),
    .set      (st_set),
    .clr      (st_clr),
    .set_rd   (STATUS_REG),
    .set_data (pipe_st_data),
    .v        (st_v),
    .rd       (st_rd),
    .data     (st_data)
  );

  wb_pending_slot u_md_slot (
    .clock    (clock),
    .reset    (reset),
    .set      (md_set),
    .clr      (md_clr),
    .set_rd   (md_rd),
    .set_data (md_data),
    .v        (md_v),
    .rd       (md_prd),
    .data     (md_pdata)
  );

  always_comb begin
    md_force  = md_v & (wait_cnt_q == LIMIT);
    stall_int = st_v | md_exc_v_q | md_force;
    pipe_pw   = pipe_we & (pipe_rd != REG_ZERO);
    pipe_any  = ~stall_int & (pipe_pw | pipe_st_we);

    grant = G_NONE;
    priority case (1'b1)
      st_v:       grant = G_ST;
      md_exc_v_q: grant = G_MDEXC;
      md_force:   grant = G_MD;
      pipe_any:   grant = pipe_pw ? G_PIPE : G_PIPE_ST;
      md_v:       grant = G_MD;
      default:    grant = G_NONE;
    endcase

    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;
    unique case (grant)
      G_ST: begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = st_rd;
        data_writeReg    = st_data;
      end
      G_MDEXC: begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = STATUS_REG;
        data_writeReg    = 32'd1;
      end
      G_MD: begin
        // r0 destinations still drain the slot but never use the port
        if (md_prd != REG_ZERO) begin
          ctrl_writeEnable = 1'b1;
          ctrl_writeReg    = md_prd;
          data_writeReg    = md_pdata;
        end
      end
      G_PIPE: begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = pipe_rd;
        data_writeReg    = pipe_data;
      end
      G_PIPE_ST: begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = STATUS_REG;
        data_writeReg    = pipe_st_data;
      end
      default: ;
    endcase

    if (reset) begin
      ctrl_writeEnable = 1'b0;
      ctrl_writeReg    = '0;
      data_writeReg    = '0;
    end

    md_ready   = ~md_v & ~reset;
    stall_pipe = stall_int & ~reset;

    st_set = (grant == G_PIPE) & pipe_st_we;
    st_clr = (grant == G_ST);
    md_set = md_valid & md_ready;
    md_clr = (grant == G_MD);

    md_exc_d = md_set ? md_exception : md_exc_q;

    md_exc_v_d = md_exc_v_q;
    if (grant == G_MDEXC) md_exc_v_d = 1'b0;
    if (md_clr)           md_exc_v_d = md_exc_q;

    wait_cnt_d = wait_cnt_q;
    if (!md_v || md_clr)       wait_cnt_d = '0;
    else if (wait_cnt_q < LIMIT) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      md_exc_q   <= 1'b0;
      md_exc_v_q <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      md_exc_q   <= md_exc_d;
      md_exc_v_q <= md_exc_v_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a queue-free reference model
// checked every cycle plus literal expectations for each scenario.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we, pipe_st_we, md_valid, md_exception;
  logic [4:0]  pipe_rd, md_rd;
  logic [31:0] pipe_data, pipe_st_data, md_data;
  logic        md_ready, stall_pipe, we;
  logic [4:0]  wreg;
  logic [31:0] wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clock            (clk),
    .reset            (rst),
    .pipe_we          (pipe_we),
    .pipe_rd          (pipe_rd),
    .pipe_data        (pipe_data),
    .pipe_st_we       (pipe_st_we),
    .pipe_st_data     (pipe_st_data),
    .md_valid         (md_valid),
    .md_rd            (md_rd),
    .md_data          (md_data),
    .md_exception     (md_exception),
    .md_ready         (md_ready),
    .stall_pipe       (stall_pipe),
    .ctrl_writeEnable (we),
    .ctrl_writeReg    (wreg),
    .data_writeReg    (wdata)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: pending status write, pending md result,
  // owed md status write, and how many cycles md has been waiting.
  bit          m_st_v;
  logic [31:0] m_st_d;
  bit          m_md_v;
  logic [4:0]  m_md_rd;
  logic [31:0] m_md_d;
  bit          m_md_exc;
  bit          m_exc_owed;
  int          m_wait;

  bit          e_we, e_stall, e_ready, md_served, forced;
  logic [4:0]  e_reg;
  logic [31:0] e_data;

  always @(negedge clk) begin
    e_we = 0; e_reg = 0; e_data = 0; md_served = 0;
    if (rst) begin
      e_stall = 0;
      e_ready = 0;
    end else begin
      forced  = m_md_v && (m_wait >= 4);
      e_stall = m_st_v || m_exc_owed || forced;
      e_ready = !m_md_v;
      if (m_st_v) begin
        e_we = 1; e_reg = 30; e_data = m_st_d;
      end else if (m_exc_owed) begin
        e_we = 1; e_reg = 30; e_data = 1;
      end else if (forced) begin
        md_served = 1;
      end else if (pipe_we && pipe_rd != 0) begin
        e_we = 1; e_reg = pipe_rd; e_data = pipe_data;
      end else if (pipe_st_we) begin
        e_we = 1; e_reg = 30; e_data = pipe_st_data;
      end else if (m_md_v) begin
        md_served = 1;
      end
      if (md_served && m_md_rd != 0) begin
        e_we = 1; e_reg = m_md_rd; e_data = m_md_d;
      end
    end

    chk("m_we", {31'd0, we}, {31'd0, e_we});
    chk("m_stall", {31'd0, stall_pipe}, {31'd0, e_stall});
    chk("m_ready", {31'd0, md_ready}, {31'd0, e_ready});
    if (e_we) begin
      chk("m_reg", {27'd0, wreg}, {27'd0, e_reg});
      chk("m_data", wdata, e_data);
    end
    if (rst) begin
      chk("m_rst_reg", {27'd0, wreg}, 32'd0);
      chk("m_rst_data", wdata, 32'd0);
    end

    if (rst) begin
      m_st_v = 0; m_md_v = 0; m_exc_owed = 0; m_wait = 0; m_md_exc = 0;
    end else begin
      if (m_st_v) m_st_v = 0;
      else if (m_exc_owed) m_exc_owed = 0;
      else if (!e_stall && pipe_we && pipe_rd != 0 && pipe_st_we) begin
        m_st_v = 1; m_st_d = pipe_st_data;
      end
      if (m_md_v && !md_served) m_wait = (m_wait < 4) ? m_wait + 1 : 4;
      else m_wait = 0;
      if (md_served) begin
        m_md_v = 0;
        m_exc_owed = m_md_exc;
      end else if (!m_md_v && md_valid) begin
        m_md_v = 1; m_md_rd = md_rd; m_md_d = md_data; m_md_exc = md_exception;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_we = 0; pipe_rd = 0; pipe_data = 0;
    pipe_st_we = 0; pipe_st_data = 0;
    md_valid = 0; md_rd = 0; md_data = 0; md_exception = 0;
  endtask

  task automatic see(string nm, bit x_we, int x_reg, int x_data, bit x_stall);
    chk({nm, "_we"}, {31'd0, we}, {31'd0, x_we});
    if (x_we) begin
      chk({nm, "_reg"}, {27'd0, wreg}, x_reg);
      chk({nm, "_data"}, wdata, x_data);
    end
    chk({nm, "_stall"}, {31'd0, stall_pipe}, {31'd0, x_stall});
  endtask

  initial begin
    idle();
    rst = 1;
    step();
    at_neg();
    see("rst", 0, 0, 0, 0);
    chk("rst_ready", {31'd0, md_ready}, 32'd0);
    step();
    rst = 0;
    at_neg();
    chk("post_rst_ready", {31'd0, md_ready}, 32'd1);

    // 1: plain pipe write
    step();
    pipe_we = 1; pipe_rd = 5; pipe_data = 32'h12;
    at_neg();
    see("t1", 1, 5, 32'h12, 0);
    step();
    idle();

    // 2: primary then rstatus on the next cycle
    pipe_we = 1; pipe_rd = 3; pipe_data = 32'h7FFF_FFFF;
    pipe_st_we = 1; pipe_st_data = 32'd1;
    at_neg();
    see("t2c0", 1, 3, 32'h7FFF_FFFF, 0);
    step();
    idle();
    at_neg();
    see("t2c1", 1, 30, 1, 1);
    step();
    at_neg();
    see("t2c2", 0, 0, 0, 0);

    // 3: md capture and one-cycle-later write
    step();
    md_valid = 1; md_rd = 7; md_data = 32'h64;
    at_neg();
    chk("t3c0_ready", {31'd0, md_ready}, 32'd1);
    see("t3c0", 0, 0, 0, 0);
    step();
    idle();
    at_neg();
    chk("t3c1_ready", {31'd0, md_ready}, 32'd0);
    see("t3c1", 1, 7, 32'h64, 0);
    step();
    at_neg();
    chk("t3c2_ready", {31'd0, md_ready}, 32'd1);

    // 4: md starved by four pipe writes, then forced
    step();
    md_valid = 1; md_rd = 7; md_data = 32'hAA;
    step();
    idle();
    for (int i = 1; i <= 4; i++) begin
      pipe_we = 1; pipe_rd = 5'(i); pipe_data = 32'h100 + i;
      at_neg();
      see($sformatf("t4p%0d", i), 1, i, 32'h100 + i, 0);
      step();
    end
    pipe_we = 1; pipe_rd = 5; pipe_data = 32'h105;
    at_neg();
    see("t4force", 1, 7, 32'hAA, 1);
    step();
    at_neg();
    see("t4resume", 1, 5, 32'h105, 0);
    chk("t4_ready", {31'd0, md_ready}, 32'd1);
    step();
    idle();

    // 5: md exception raises rstatus after its result
    md_valid = 1; md_rd = 9; md_data = 0; md_exception = 1;
    step();
    idle();
    at_neg();
    see("t5c1", 1, 9, 0, 0);
    step();
    at_neg();
    see("t5c2", 1, 30, 1, 1);
    step();
    at_neg();
    see("t5c3", 0, 0, 0, 0);

    // 6a: pipe write to r0 lets md drain
    step();
    md_valid = 1; md_rd = 11; md_data = 32'h55;
    step();
    idle();
    pipe_we = 1; pipe_rd = 0; pipe_data = 32'hDEAD;
    at_neg();
    see("t6a", 1, 11, 32'h55, 0);
    step();
    idle();

    // 7: md to r0 with exception: no write, then rstatus
    md_valid = 1; md_rd = 0; md_data = 32'h9; md_exception = 1;
    step();
    idle();
    at_neg();
    see("t7c1", 0, 0, 0, 0);
    step();
    at_neg();
    see("t7c2", 1, 30, 1, 1);
    step();

    // 6b: reset discards pending status and md results
    pipe_we = 1; pipe_rd = 2; pipe_data = 32'h2;
    pipe_st_we = 1; pipe_st_data = 32'hBEEF;
    md_valid = 1; md_rd = 12; md_data = 32'h77;
    at_neg();
    see("t6b_c0", 1, 2, 32'h2, 0);
    step();
    idle();
    rst = 1;
    at_neg();
    see("t6b_rst", 0, 0, 0, 0);
    chk("t6b_rst_ready", {31'd0, md_ready}, 32'd0);
    step();
    rst = 0;
    at_neg();
    see("t6b_after", 0, 0, 0, 0);
    chk("t6b_ready", {31'd0, md_ready}, 32'd1);
    step();
    at_neg();
    see("t6b_after2", 0, 0, 0, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
